// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame constants, receiver state encoding and counter width helper
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int BIT_W     = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT
    } rx_state_e;

    // Width of a down-counter spanning one bit period; never narrower than one bit
    function automatic int cnt_w(input int cycles_per_bit);
        return (cycles_per_bit > 2) ? $clog2(cycles_per_bit) : 1;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchroniser for an asynchronous input with selectable reset value
module uart_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling, framing-error strobe and running byte checksum
module uart_rx
    import uart_pkg::*;
#(
    parameter int cycles_per_bit = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_serial,
    output logic [7:0]  o_data,
    output logic        o_valid,
    output logic        o_frame_err,
    output logic        o_idle,
    output logic [31:0] o_sum
);

    localparam int            CW      = cnt_w(cycles_per_bit);
    localparam logic [CW-1:0] HALF_M1 = CW'(cycles_per_bit / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(cycles_per_bit - 1);

    logic                 s2;
    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cyc_q, cyc_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic [31:0]          sum_q, sum_d;

    uart_sync #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (i_serial),
        .q_o (s2)
    );

    // State, counters, shift register and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            sum_q   <= sum_d;
        end
    end

    // Frame sequencing: each sample is taken when the bit-period counter reaches zero
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        sum_d   = sum_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!s2) begin
                    state_d = START;
                    cyc_d   = HALF_M1;
                end
            end
            START: begin
                if (cyc_q != '0) begin
                    cyc_d = cyc_q - 1'b1;
                end else if (!s2) begin
                    state_d = DATA;
                    cyc_d   = FULL_M1;
                    bit_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (cyc_q != '0) begin
                    cyc_d = cyc_q - 1'b1;
                end else begin
                    shreg_d = {s2, shreg_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 1'b1;
                    cyc_d   = FULL_M1;
                    state_d = (bit_q == BIT_W'(DATA_BITS - 1)) ? STOP : DATA;
                end
            end
            STOP: begin
                if (cyc_q != '0) begin
                    cyc_d = cyc_q - 1'b1;
                end else if (s2) begin
                    data_d  = shreg_q;
                    sum_d   = sum_q + 32'(shreg_q);
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    ferr_d  = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (s2) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
    assign o_idle      = (state_q == IDLE);
    assign o_sum       = sum_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized frame stimulus for three receiver builds checked against a byte-level model
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ser4 = 1'b1, ser2 = 1'b1, ser7 = 1'b1;
    logic [7:0]  d4_data, d2_data, d7_data;
    logic        d4_valid, d2_valid, d7_valid;
    logic        d4_ferr, d2_ferr, d7_ferr;
    logic        d4_idle, d2_idle, d7_idle;
    logic [31:0] d4_sum, d2_sum, d7_sum;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int lat4 = 0;
    int f4 = 0, f2 = 0, f7 = 0;
    bit both = 1'b0;
    logic [7:0] q4[$], q2[$], q7[$];

    uart_rx #(.cycles_per_bit(4)) dut4 (
        .clk(clk), .rst(rst), .i_serial(ser4), .o_data(d4_data), .o_valid(d4_valid),
        .o_frame_err(d4_ferr), .o_idle(d4_idle), .o_sum(d4_sum)
    );
    uart_rx #(.cycles_per_bit(2)) dut2 (
        .clk(clk), .rst(rst), .i_serial(ser2), .o_data(d2_data), .o_valid(d2_valid),
        .o_frame_err(d2_ferr), .o_idle(d2_idle), .o_sum(d2_sum)
    );
    uart_rx #(.cycles_per_bit(7)) dut7 (
        .clk(clk), .rst(rst), .i_serial(ser7), .o_data(d7_data), .o_valid(d7_valid),
        .o_frame_err(d7_ferr), .o_idle(d7_idle), .o_sum(d7_sum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Collect every strobe the receivers emit
    always @(negedge clk) begin
        if (rst) begin
            q4.delete(); q2.delete(); q7.delete();
            f4 = 0; f2 = 0; f7 = 0;
        end else begin
            if (d4_valid) begin q4.push_back(d4_data); lat4 = cyc; end
            if (d2_valid) q2.push_back(d2_data);
            if (d7_valid) q7.push_back(d7_data);
            if (d4_ferr) f4++;
            if (d2_ferr) f2++;
            if (d7_ferr) f7++;
            if ((d4_valid && d4_ferr) || (d2_valid && d2_ferr) || (d7_valid && d7_ferr)) both = 1'b1;
        end
    end

    task automatic set_line(input int w, input logic v);
        case (w)
            2: ser2 = v;
            7: ser7 = v;
            default: ser4 = v;
        endcase
    endtask

    // Transmit one 8N1 frame (one stop bit of value stop_v) on the line of the chosen build
    task automatic send(input int w, input logic [7:0] b, input logic stop_v);
        int cpb;
        cpb = (w == 2) ? 2 : (w == 7) ? 7 : 4;
        set_line(w, 1'b0);
        repeat (cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            set_line(w, b[i]);
            repeat (cpb) @(negedge clk);
        end
        set_line(w, stop_v);
        repeat (cpb) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ser4 = 1'b1; ser2 = 1'b1; ser7 = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (d4_data !== 8'h00) begin miscompares++; $display("FAIL reset_data got %h want 00", d4_data); end
        vectors++;
        if (d4_valid !== 1'b0 || d4_ferr !== 1'b0) begin
            miscompares++; $display("FAIL reset_strobes got valid=%b ferr=%b want 0 0", d4_valid, d4_ferr);
        end
        vectors++;
        if (d4_idle !== 1'b1) begin miscompares++; $display("FAIL reset_idle got %b want 1", d4_idle); end
        vectors++;
        if (d4_sum !== 32'h0) begin miscompares++; $display("FAIL reset_sum got %h want 0", d4_sum); end
    endtask

    task automatic test_single();
        int k0;
        do_reset();
        k0 = cyc + 1;
        send(4, 8'hA5, 1'b1);
        repeat (12) @(negedge clk);
        vectors++;
        if (q4.size() !== 1) begin miscompares++; $display("FAIL single_count got %0d want 1", q4.size()); end
        vectors++;
        if (d4_data !== 8'hA5) begin miscompares++; $display("FAIL single_data got %h want a5", d4_data); end
        vectors++;
        if (d4_sum !== 32'hA5) begin miscompares++; $display("FAIL single_sum got %h want a5", d4_sum); end
        vectors++;
        if (lat4 - k0 !== 40) begin miscompares++; $display("FAIL single_latency got %0d want 40", lat4 - k0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp[$];
        logic [7:0] b;
        logic [31:0] s;
        do_reset();
        exp = '{8'h00, 8'hFF, 8'h55, 8'h80};
        foreach (exp[i]) send(4, exp[i], 1'b1);
        repeat (12) @(negedge clk);
        vectors++;
        if (d4_sum !== 32'h1D4) begin miscompares++; $display("FAIL stream_fixed_sum got %h want 1d4", d4_sum); end
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom_range(0, 255));
            exp.push_back(b);
            send(4, b, 1'b1);
            repeat ($urandom_range(0, 3) * 4) @(negedge clk);
        end
        repeat (12) @(negedge clk);
        s = 0;
        foreach (exp[i]) s += 32'(exp[i]);
        vectors++;
        if (q4.size() !== exp.size()) begin
            miscompares++; $display("FAIL stream_count got %0d want %0d", q4.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < q4.size(); i++) begin
            vectors++;
            if (q4[i] !== exp[i]) begin miscompares++; $display("FAIL stream_byte%0d got %h want %h", i, q4[i], exp[i]); end
        end
        vectors++;
        if (d4_sum !== s) begin miscompares++; $display("FAIL stream_sum got %h want %h", d4_sum, s); end
        vectors++;
        if (f4 !== 0 || both !== 1'b0) begin miscompares++; $display("FAIL stream_ferr got %0d/%b want 0/0", f4, both); end
    endtask

    task automatic test_glitch();
        do_reset();
        ser4 = 1'b0;
        @(negedge clk);
        ser4 = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (d4_idle !== 1'b0) begin miscompares++; $display("FAIL glitch_start got idle=%b want 0", d4_idle); end
        repeat (20) @(negedge clk);
        vectors++;
        if (d4_idle !== 1'b1) begin miscompares++; $display("FAIL glitch_idle got %b want 1", d4_idle); end
        vectors++;
        if (q4.size() !== 0 || f4 !== 0) begin
            miscompares++; $display("FAIL glitch_strobes got valid=%0d ferr=%0d want 0 0", q4.size(), f4);
        end
    endtask

    task automatic test_frame_err();
        logic [7:0] g;
        do_reset();
        g = 8'($urandom_range(1, 255));
        send(4, g, 1'b1);
        repeat (4) @(negedge clk);
        send(4, 8'h3C, 1'b0);
        repeat (20) @(negedge clk);
        vectors++;
        if (f4 !== 1) begin miscompares++; $display("FAIL ferr_count got %0d want 1", f4); end
        vectors++;
        if (q4.size() !== 1) begin miscompares++; $display("FAIL ferr_valid_count got %0d want 1", q4.size()); end
        vectors++;
        if (d4_data !== g) begin miscompares++; $display("FAIL ferr_data_held got %h want %h", d4_data, g); end
        vectors++;
        if (d4_idle !== 1'b0) begin miscompares++; $display("FAIL ferr_wait got idle=%b want 0", d4_idle); end
        ser4 = 1'b1;
        repeat (4) @(negedge clk);
        vectors++;
        if (d4_idle !== 1'b1) begin miscompares++; $display("FAIL ferr_rearm got idle=%b want 1", d4_idle); end
        send(4, 8'h12, 1'b1);
        repeat (12) @(negedge clk);
        vectors++;
        if (q4.size() !== 2 || d4_data !== 8'h12) begin
            miscompares++; $display("FAIL ferr_next got n=%0d data=%h want 2 12", q4.size(), d4_data);
        end
        vectors++;
        if (d4_sum !== 32'(g) + 32'h12) begin
            miscompares++; $display("FAIL ferr_sum got %h want %h", d4_sum, 32'(g) + 32'h12);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        do_reset();
        send(4, 8'($urandom_range(1, 255)), 1'b1);
        repeat (4) @(negedge clk);
        b = 8'h77;
        ser4 = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            ser4 = b[i];
            repeat (4) @(negedge clk);
        end
        ser4 = b[3];
        @(negedge clk);
        vectors++;
        if (d4_idle !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got idle=%b want 0", d4_idle); end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (d4_data !== 8'h00 || d4_sum !== 32'h0 || d4_idle !== 1'b1 || d4_valid !== 1'b0 || d4_ferr !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_outputs got data=%h sum=%h idle=%b v=%b fe=%b want 00 0 1 0 0",
                     d4_data, d4_sum, d4_idle, d4_valid, d4_ferr);
        end
        rst = 1'b0;
        ser4 = 1'b1;
        repeat (48) @(negedge clk);
        vectors++;
        if (q4.size() !== 0 || f4 !== 0) begin
            miscompares++; $display("FAIL midrst_strobes got valid=%0d ferr=%0d want 0 0", q4.size(), f4);
        end
        send(4, 8'h42, 1'b1);
        repeat (12) @(negedge clk);
        vectors++;
        if (q4.size() !== 1 || d4_data !== 8'h42 || d4_sum !== 32'h42) begin
            miscompares++; $display("FAIL midrst_next got n=%0d data=%h sum=%h want 1 42 42", q4.size(), d4_data, d4_sum);
        end
    endtask

    task automatic test_params();
        logic [7:0] e2[$], e7[$];
        logic [31:0] s2, s7;
        do_reset();
        e2 = '{8'hC3};
        e7 = '{8'hC3};
        for (int i = 0; i < 3; i++) begin
            e2.push_back(8'($urandom_range(0, 255)));
            e7.push_back(8'($urandom_range(0, 255)));
        end
        fork
            foreach (e2[i]) send(2, e2[i], 1'b1);
            foreach (e7[i]) send(7, e7[i], 1'b1);
        join
        repeat (25) @(negedge clk);
        s2 = 0; s7 = 0;
        foreach (e2[i]) s2 += 32'(e2[i]);
        foreach (e7[i]) s7 += 32'(e7[i]);
        vectors++;
        if (q2.size() !== 4 || q7.size() !== 4) begin
            miscompares++; $display("FAIL params_count got %0d/%0d want 4/4", q2.size(), q7.size());
        end
        for (int i = 0; i < 4 && i < q2.size(); i++) begin
            vectors++;
            if (q2[i] !== e2[i]) begin miscompares++; $display("FAIL cpb2_byte%0d got %h want %h", i, q2[i], e2[i]); end
        end
        for (int i = 0; i < 4 && i < q7.size(); i++) begin
            vectors++;
            if (q7[i] !== e7[i]) begin miscompares++; $display("FAIL cpb7_byte%0d got %h want %h", i, q7[i], e7[i]); end
        end
        vectors++;
        if (d2_sum !== s2 || d7_sum !== s7) begin
            miscompares++; $display("FAIL params_sum got %h/%h want %h/%h", d2_sum, d7_sum, s2, s7);
        end
        vectors++;
        if (f2 !== 0 || f7 !== 0 || both !== 1'b0) begin
            miscompares++; $display("FAIL params_ferr got %0d/%0d/%b want 0/0/0", f2, f7, both);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        test_params();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
